// File: rtl/key_search_ctrl.sv
// key_search_ctrl
//
// Brute-force key-search controller for the RC4 decrypt core. For each
// candidate key it launches one decryption, waits for the core to finish,
// then scans the decrypted-message RAM one byte at a time. A key is accepted
// when every byte is lowercase ASCII (8'h61..8'h7A) or space (8'h20);
// otherwise the key is incremented and the core relaunched, until a key is
// accepted (FOUND) or KEY_MAX has been rejected (FAIL).
//
// Optional feature macro: KEY_SEARCH_EARLY_ABORT_EN
//   defined   - the scan stops at the first invalid byte and moves to the
//               next key immediately.
//   undefined - all MSG_LEN bytes are always scanned; the decision is made
//               at the last byte.
//   The accepted key is the same either way; only the cycle count differs.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset, forces IDLE
//   start         in   begin a search (sampled only in IDLE/FOUND/FAIL)
//   secret_key    out  current candidate key (24 bits) to the decrypt core
//   crack_start   out  one-cycle pulse launching the decrypt core
//   crack_done    in   one-cycle pulse: decrypted RAM is complete
//   decrypted_adr out  read address into the decrypted RAM
//   decrypted_q   in   RAM read data, valid one cycle after the address
//   busy          out  high while a search is in progress
//   key_found     out  high in FOUND
//   key_fail      out  high in FAIL
//
// Every output is a register; no input reaches an output combinationally.

module key_search_ctrl #(
    parameter int          MSG_LEN = 32,
    parameter logic [23:0] KEY_MIN = 24'h000000,
    parameter logic [23:0] KEY_MAX = 24'h3FFFFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [23:0]                secret_key,
    output logic                       crack_start,
    input  logic                       crack_done,
    output logic [$clog2(MSG_LEN)-1:0] decrypted_adr,
    input  logic [7:0]                 decrypted_q,
    output logic                       busy,
    output logic                       key_found,
    output logic                       key_fail
);

    localparam int            AW       = $clog2(MSG_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RD_ADR,
        RD_WAIT,
        CHECK,
        NEXT_KEY,
        FOUND,
        FAIL
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] idx_reg;
    logic          bad_reg;

    logic byte_bad;
    logic scan_bad;
    logic last_byte;
    logic abort_now;

    // Byte classification is only consumed inside CHECK, where the RAM data
    // for the current index is stable (address held since RD_ADR).
    assign byte_bad  = !(((decrypted_q >= 8'h61) && (decrypted_q <= 8'h7A)) ||
                         (decrypted_q == 8'h20));
    assign scan_bad  = bad_reg | byte_bad;
    assign last_byte = (idx_reg == LAST_IDX);

`ifdef KEY_SEARCH_EARLY_ABORT_EN
    assign abort_now = byte_bad;
`else
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            secret_key    <= 24'h000000;
            crack_start   <= 1'b0;
            decrypted_adr <= '0;
            busy          <= 1'b0;
            key_found     <= 1'b0;
            key_fail      <= 1'b0;
            idx_reg       <= '0;
            bad_reg       <= 1'b0;
        end else begin
            // crack_start is only ever high for the single LAUNCH cycle.
            crack_start <= 1'b0;

            case (state_reg)
                IDLE, FOUND, FAIL: begin
                    if (start) begin
                        state_reg   <= LAUNCH;
                        secret_key  <= KEY_MIN;
                        idx_reg     <= '0;
                        bad_reg     <= 1'b0;
                        crack_start <= 1'b1;
                        busy        <= 1'b1;
                        key_found   <= 1'b0;
                        key_fail    <= 1'b0;
                    end
                end

                LAUNCH: begin
                    state_reg <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (crack_done) begin
                        state_reg     <= RD_ADR;
                        idx_reg       <= '0;
                        decrypted_adr <= '0;
                    end
                end

                // The address register is loaded on entry to RD_ADR, so it
                // is on the bus for the whole RD_ADR cycle; RD_WAIT covers
                // the RAM's registered read.
                RD_ADR: begin
                    state_reg <= RD_WAIT;
                end

                RD_WAIT: begin
                    state_reg <= CHECK;
                end

                CHECK: begin
                    bad_reg <= scan_bad;
                    if (abort_now || (last_byte && scan_bad)) begin
                        state_reg <= NEXT_KEY;
                    end else if (last_byte) begin
                        state_reg <= FOUND;
                        busy      <= 1'b0;
                        key_found <= 1'b1;
                    end else begin
                        state_reg     <= RD_ADR;
                        idx_reg       <= idx_reg + 1'b1;
                        decrypted_adr <= idx_reg + 1'b1;
                    end
                end

                NEXT_KEY: begin
                    if (secret_key == KEY_MAX) begin
                        // Range exhausted: the key stays at KEY_MAX.
                        state_reg <= FAIL;
                        busy      <= 1'b0;
                        key_fail  <= 1'b1;
                    end else begin
                        state_reg   <= LAUNCH;
                        secret_key  <= secret_key + 24'd1;
                        idx_reg     <= '0;
                        bad_reg     <= 1'b0;
                        crack_start <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Self-checking bench for key_search_ctrl (MSG_LEN=4, keys 0..15).
// A behavioural decrypt core answers each crack_start after a fixed latency
// by filling a 4-byte RAM with a message chosen by the current scenario.
// Every crack_start pops the expected key from a scoreboard queue.

module tb_key_search_ctrl;

    localparam int          MSG_LEN  = 4;
    localparam logic [23:0] KMIN     = 24'd0;
    localparam logic [23:0] KMAX     = 24'd15;
    localparam int          CORE_LAT = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic        crack_start;
    logic        crack_done;
    logic        model_done;
    logic        manual_done;
    logic [1:0]  decrypted_adr;
    logic [7:0]  decrypted_q;
    logic        busy;
    logic        key_found;
    logic        key_fail;

    assign crack_done = model_done | manual_done;

    always #5 clk = ~clk;

    key_search_ctrl #(
        .MSG_LEN (MSG_LEN),
        .KEY_MIN (KMIN),
        .KEY_MAX (KMAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .secret_key    (secret_key),
        .crack_start   (crack_start),
        .crack_done    (crack_done),
        .decrypted_adr (decrypted_adr),
        .decrypted_q   (decrypted_q),
        .busy          (busy),
        .key_found     (key_found),
        .key_fail      (key_fail)
    );

    // Decrypted-message RAM with registered read.
    logic [7:0] mem [0:3];
    always @(posedge clk) decrypted_q <= mem[decrypted_adr];

    // Scenario tables.
    logic [7:0] abcd   [0:3]  = '{8'h61, 8'h62, 8'h63, 8'h64};
    logic [7:0] cs_tab [0:15] = '{8'h20, 8'h7A, 8'h61, 8'h60,
                                  8'h7B, 8'h61, 8'h61, 8'h61,
                                  8'h61, 8'h61, 8'h1F, 8'h61,
                                  8'h20, 8'h7A, 8'h61, 8'h62};

    int          mode;
    int          good_key;
    logic        model_en;
    int          core_cnt;
    logic [23:0] core_key;
    int          cyc;
    int          launch_count;
    int          max_adr0;
    logic        track0;
    logic [23:0] exp_key_q [$];
    int          done_cyc_q [$];
    int          launch_cyc_q [$];
    int          tests_run;
    int          tests_failed;

    // mode 0: "abcd" for good_key, else an 'A' at position key%4
    // mode 1: character-boundary table for keys 0..3 (key 3 valid)
    // mode 2: key 0 -> 'A',"bcd"; other keys -> "abcd"
    function automatic logic [7:0] msg_byte(input logic [23:0] key, input int i);
        logic [7:0] b;
        b = 8'h00;
        case (mode)
            0: begin
                if (int'(key) == good_key) b = abcd[i];
                else if (i == int'(key % 24'd4)) b = 8'h41;
                else b = abcd[i];
            end
            1: begin
                if (key < 24'd4) b = cs_tab[int'(key) * 4 + i];
                else b = 8'h00;
            end
            default: begin
                if (key == 24'd0 && i == 0) b = 8'h41;
                else b = abcd[i];
            end
        endcase
        return b;
    endfunction

    // One clock step: advances the core model and the launch scoreboard.
    task automatic tick();
        logic [23:0] exp_k;
        @(negedge clk);
        cyc++;
        if (track0) begin
            if (secret_key != 24'd0) track0 = 1'b0;
            else if (int'(decrypted_adr) > max_adr0) max_adr0 = int'(decrypted_adr);
        end
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                for (int i = 0; i < MSG_LEN; i++) mem[i] = msg_byte(core_key, i);
                model_done = 1'b1;
                done_cyc_q.push_back(cyc);
                if (core_key == 24'd0) begin
                    track0   = 1'b1;
                    max_adr0 = 0;
                end
            end
        end else begin
            model_done = 1'b0;
        end
        if (crack_start === 1'b1) begin
            launch_count++;
            launch_cyc_q.push_back(cyc);
            $display("[TB] launch key=%0d cycle=%0d", secret_key, cyc);
            tests_run++;
            if (exp_key_q.size() == 0) begin
                tests_failed++;
                $display("FAIL launch_key: unexpected crack_start with key %0d, required no launch", secret_key);
            end else begin
                exp_k = exp_key_q.pop_front();
                if (secret_key !== exp_k) begin
                    tests_failed++;
                    $display("FAIL launch_key: got %0d, required %0d", secret_key, exp_k);
                end
            end
            if (model_en) begin
                core_key = secret_key;
                core_cnt = CORE_LAT;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_keys(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) exp_key_q.push_back(24'(k));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (busy === 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
        end
        $display("[TB] search end key=%0d found=%b key_fail=%b", secret_key, key_found, key_fail);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests_run++; if (secret_key !== 24'd0) begin tests_failed++; $display("FAIL rst_key: got %0d, required 0", secret_key); end
        tests_run++; if (crack_start !== 1'b0) begin tests_failed++; $display("FAIL rst_crack_start: got %b, required 0", crack_start); end
        tests_run++; if (decrypted_adr !== 2'd0) begin tests_failed++; $display("FAIL rst_adr: got %0d, required 0", decrypted_adr); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b, required 0", busy); end
        tests_run++; if (key_found !== 1'b0) begin tests_failed++; $display("FAIL rst_found: got %b, required 0", key_found); end
        tests_run++; if (key_fail !== 1'b0) begin tests_failed++; $display("FAIL rst_key_fail: got %b, required 0", key_fail); end
        reset = 1'b0;
        repeat (2) tick();
        $display("[TB] reset check done");
    endtask

    task automatic test_found();
        int lc0;
        mode = 0; good_key = 3; lc0 = launch_count;
        push_keys(0, 3);
        pulse_start();
        wait_idle(2000);
        tests_run++; if (key_found !== 1'b1) begin tests_failed++; $display("FAIL found_flag: got %b, required 1", key_found); end
        tests_run++; if (key_fail !== 1'b0) begin tests_failed++; $display("FAIL found_no_fail: got %b, required 0", key_fail); end
        tests_run++; if (secret_key !== 24'd3) begin tests_failed++; $display("FAIL found_key: got %0d, required 3", secret_key); end
        tests_run++; if (launch_count - lc0 != 4) begin tests_failed++; $display("FAIL found_launches: got %0d, required 4", launch_count - lc0); end
        tests_run++; if (exp_key_q.size() != 0) begin tests_failed++; $display("FAIL found_queue: got %0d pending, required 0", exp_key_q.size()); end
    endtask

    task automatic test_fail();
        int lc0;
        mode = 0; good_key = -1; lc0 = launch_count;
        push_keys(0, 15);
        pulse_start();
        wait_idle(4000);
        tests_run++; if (key_fail !== 1'b1) begin tests_failed++; $display("FAIL fail_flag: got %b, required 1", key_fail); end
        tests_run++; if (key_found !== 1'b0) begin tests_failed++; $display("FAIL fail_no_found: got %b, required 0", key_found); end
        tests_run++; if (secret_key !== KMAX) begin tests_failed++; $display("FAIL fail_key: got %0d, required 15", secret_key); end
        tests_run++; if (launch_count - lc0 != 16) begin tests_failed++; $display("FAIL fail_launches: got %0d, required 16", launch_count - lc0); end
        repeat (40) tick();
        tests_run++; if (launch_count - lc0 != 16) begin tests_failed++; $display("FAIL fail_no_17th: got %0d launches, required 16", launch_count - lc0); end
        tests_run++; if (secret_key !== KMAX) begin tests_failed++; $display("FAIL fail_key_hold: got %0d, required 15", secret_key); end
    endtask

    task automatic test_charset();
        int lc0;
        mode = 1; lc0 = launch_count;
        push_keys(0, 3);
        pulse_start();
        wait_idle(2000);
        tests_run++; if (key_found !== 1'b1) begin tests_failed++; $display("FAIL cs_found: got %b, required 1", key_found); end
        tests_run++; if (secret_key !== 24'd3) begin tests_failed++; $display("FAIL cs_key: got %0d, required 3", secret_key); end
        tests_run++; if (launch_count - lc0 != 4) begin tests_failed++; $display("FAIL cs_launches: got %0d, required 4", launch_count - lc0); end
    endtask

    task automatic test_early_abort();
        int exp_gap;
        int exp_max;
        int gap;
`ifdef KEY_SEARCH_EARLY_ABORT_EN
        exp_gap = 5;
        exp_max = 0;
`else
        exp_gap = 3 * MSG_LEN + 2;
        exp_max = MSG_LEN - 1;
`endif
        mode = 2;
        done_cyc_q.delete();
        launch_cyc_q.delete();
        push_keys(0, 1);
        pulse_start();
        wait_idle(2000);
        tests_run++; if (key_found !== 1'b1) begin tests_failed++; $display("FAIL ea_found: got %b, required 1", key_found); end
        tests_run++; if (secret_key !== 24'd1) begin tests_failed++; $display("FAIL ea_key: got %0d, required 1", secret_key); end
        gap = -1;
        if (done_cyc_q.size() >= 1 && launch_cyc_q.size() >= 2) gap = launch_cyc_q[1] - done_cyc_q[0];
        tests_run++; if (gap != exp_gap) begin tests_failed++; $display("FAIL ea_done_to_launch: got %0d cycles, required %0d", gap, exp_gap); end
        tests_run++; if (max_adr0 != exp_max) begin tests_failed++; $display("FAIL ea_max_adr_key0: got %0d, required %0d", max_adr0, exp_max); end
    endtask

    task automatic test_back_to_back();
        int lc0;
        int n;
        mode = 0; good_key = 3; lc0 = launch_count;
        push_keys(0, 3);
        pulse_start();
        n = 0;
        while (model_done !== 1'b1 && n < 100) begin tick(); n++; end
        // Hold start across the first byte's RD_ADR/RD_WAIT/CHECK and beyond.
        start = 1'b1;
        repeat (8) tick();
        start = 1'b0;
        wait_idle(2000);
        tests_run++; if (key_found !== 1'b1) begin tests_failed++; $display("FAIL busy_start_found: got %b, required 1", key_found); end
        tests_run++; if (secret_key !== 24'd3) begin tests_failed++; $display("FAIL busy_start_key: got %0d, required 3", secret_key); end
        tests_run++; if (launch_count - lc0 != 4) begin tests_failed++; $display("FAIL busy_start_launches: got %0d, required 4", launch_count - lc0); end
        // Restart from FOUND.
        push_keys(0, 3);
        pulse_start();
        tests_run++; if (key_found !== 1'b0) begin tests_failed++; $display("FAIL restart_found_drop: got %b, required 0", key_found); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL restart_busy: got %b, required 1", busy); end
        tests_run++; if (secret_key !== KMIN) begin tests_failed++; $display("FAIL restart_key: got %0d, required 0", secret_key); end
        wait_idle(2000);
        tests_run++; if (key_found !== 1'b1 || secret_key !== 24'd3) begin tests_failed++; $display("FAIL restart_result: got found=%b key=%0d, required found=1 key=3", key_found, secret_key); end
    endtask

    task automatic test_reset_mid();
        int lc0;
        model_en = 1'b0;
        push_keys(0, 0);
        pulse_start();
        lc0 = launch_count;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        reset = 1'b0;
        tick();
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        repeat (20) tick();
        tests_run++; if (launch_count != lc0) begin tests_failed++; $display("FAIL midrst_no_launch: got %0d extra, required 0", launch_count - lc0); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy_after: got %b, required 0", busy); end
        tests_run++; if (secret_key !== 24'd0) begin tests_failed++; $display("FAIL midrst_key: got %0d, required 0", secret_key); end
        tests_run++; if (decrypted_adr !== 2'd0) begin tests_failed++; $display("FAIL midrst_adr: got %0d, required 0", decrypted_adr); end
        tests_run++; if (key_found !== 1'b0 || key_fail !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags: got found=%b key_fail=%b, required 0/0", key_found, key_fail); end
        tests_run++; if (crack_start !== 1'b0) begin tests_failed++; $display("FAIL midrst_crack_start: got %b, required 0", crack_start); end
        model_en = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        manual_done  = 1'b0;
        model_done   = 1'b0;
        model_en     = 1'b1;
        mode         = 0;
        good_key     = -1;
        core_cnt     = 0;
        core_key     = 24'd0;
        cyc          = 0;
        launch_count = 0;
        max_adr0     = 0;
        track0       = 1'b0;
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'h00;

        test_reset();
        test_found();
        test_fail();
        test_charset();
        test_early_abort();
        test_back_to_back();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
